// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the TDC measurement sequencer.
package tdc_pkg;

   typedef enum logic [1:0] {IDLE, LAUNCH, CAPTURE, WAIT} tdc_seq_state_t;

   function automatic int hw_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/tdc_stats.sv
// Clips incoming Hamming weights to N and keeps running sum, min and max.
module tdc_stats
   import tdc_pkg::*;
#(
   parameter int N            = 64,
   parameter int HW_W         = hw_width(N),
   parameter int LOG2_SAMPLES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         acc,
   input  logic [HW_W-1:0]              hw,
   output logic [HW_W+LOG2_SAMPLES-1:0] sum,
   output logic [HW_W-1:0]              hw_min,
   output logic [HW_W-1:0]              hw_max
);

   localparam int              SUM_W = HW_W + LOG2_SAMPLES;
   localparam logic [HW_W-1:0] N_MAX = HW_W'(N);

   logic [HW_W-1:0] hw_clip;

   assign hw_clip = (hw > N_MAX) ? N_MAX : hw;

   // min starts at N on a batch clear so the first sample always wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum    <= '0;
         hw_min <= '0;
         hw_max <= '0;
      end else if (clr) begin
         sum    <= '0;
         hw_min <= N_MAX;
         hw_max <= '0;
      end else if (acc) begin
         sum <= sum + SUM_W'(hw_clip);
         if (hw_clip < hw_min) hw_min <= hw_clip;
         if (hw_clip > hw_max) hw_max <= hw_clip;
      end
   end

endmodule

// File: rtl/tdc_seq.sv
// Batch measurement sequencer: fires launch/capture pairs into the TDC and
// collects 2^LOG2_SAMPLES results, aborting a sample after TIMEOUT wait cycles.
module tdc_seq
   import tdc_pkg::*;
#(
   parameter int N            = 64,
   parameter int HW_W         = hw_width(N),
   parameter int LOG2_SAMPLES = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         start,
   output logic                         clk_launch,
   output logic                         clk_capture,
   output logic                         val_in,
   input  logic [HW_W-1:0]              hw,
   input  logic                         val_out,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [HW_W+LOG2_SAMPLES-1:0] sum,
   output logic [HW_W-1:0]              hw_min,
   output logic [HW_W-1:0]              hw_max,
   output logic [HW_W-1:0]              avg
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   tdc_seq_state_t          state, state_nxt;
   logic [LOG2_SAMPLES-1:0] smp_cnt;
   logic [TO_W-1:0]         to_cnt;
   logic                    stats_clr, stats_acc, fin, to_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // val_out wins over an expiring timeout on the same edge
   always_comb begin
      state_nxt = state;
      stats_clr = 1'b0;
      stats_acc = 1'b0;
      fin       = 1'b0;
      to_hit    = 1'b0;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (start) begin
               stats_clr = 1'b1;
               state_nxt = LAUNCH;
            end
            LAUNCH:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = WAIT;
            WAIT: begin
               if (val_out) begin
                  stats_acc = 1'b1;
                  if (smp_cnt == '1) begin
                     fin       = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     state_nxt = LAUNCH;
                  end
               end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                  to_hit    = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Pulses are registered from the next state so they line up with it exactly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_launch  <= 1'b0;
         clk_capture <= 1'b0;
         val_in      <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         smp_cnt     <= '0;
         to_cnt      <= '0;
      end else begin
         clk_launch  <= (state_nxt == LAUNCH);
         val_in      <= (state_nxt == LAUNCH);
         clk_capture <= (state_nxt == CAPTURE);
         done        <= fin | to_hit;
         if (stats_clr)   err <= 1'b0;
         else if (to_hit) err <= 1'b1;
         if (stats_clr)      smp_cnt <= '0;
         else if (stats_acc) smp_cnt <= smp_cnt + 1'b1;
         if (state == CAPTURE)   to_cnt <= '0;
         else if (state == WAIT) to_cnt <= to_cnt + TO_W'(1);
      end
   end

   tdc_stats #(
      .N            (N),
      .HW_W         (HW_W),
      .LOG2_SAMPLES (LOG2_SAMPLES)
   ) u_stats (
      .clk    (clk),
      .rst    (rst),
      .clr    (stats_clr),
      .acc    (stats_acc),
      .hw     (hw),
      .sum    (sum),
      .hw_min (hw_min),
      .hw_max (hw_max)
   );

   assign busy = (state != IDLE);
   assign avg  = sum[HW_W+LOG2_SAMPLES-1:LOG2_SAMPLES];

endmodule

// File: doc/tdc_seq.md
# tdc_seq

Measurement sequencer that drives the TDC core's launch/capture inputs and consumes its result stream. On each `start` it fires a batch of 2^LOG2_SAMPLES launch/capture pairs and waits for each `val_out`/`hw` result. It accumulates sum, min and max of the clipped Hamming weights, then reports an average. It sits beside `tdc_top` in the top level, replacing direct pin control of `clk_launch`/`clk_capture`/`val_in` when on-chip batch measurement is selected.

## Interface
Parameters:
- N, 64, TDC delay-line length; maximum valid `hw` value
- HW_W, $clog2(N)+1, width of `hw`, `hw_min`, `hw_max`, `avg`
- LOG2_SAMPLES, 4, batch size is 2^LOG2_SAMPLES
- TIMEOUT, 16, WAIT cycles allowed per sample before abort

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  block enable; low aborts to IDLE
- start  in  1  begin batch; sampled only in IDLE with en=1
- clk_launch  out  1  one-cycle launch pulse to TDC
- clk_capture  out  1  one-cycle capture pulse to TDC
- val_in  out  1  valid-in to TDC, coincident with clk_launch
- hw  in  HW_W  TDC Hamming-weight result
- val_out  in  1  TDC result valid
- busy  out  1  batch in progress
- done  out  1  one-cycle pulse at batch end (normal or timeout)
- err  out  1  sticky timeout flag for last batch
- sum  out  HW_W+LOG2_SAMPLES  sum of clipped samples
- hw_min  out  HW_W  minimum clipped sample
- hw_max  out  HW_W  maximum clipped sample
- avg  out  HW_W  sum >> LOG2_SAMPLES

## Operation
- FSM states: IDLE, LAUNCH, CAPTURE, WAIT.
- IDLE: on `start`=1 and `en`=1:
  - clear sum=0, hw_min=N, hw_max=0, err=0, sample count=0
  - go to LAUNCH
- LAUNCH lasts exactly one cycle:
  - clk_launch=1 and val_in=1
  - go to CAPTURE
- CAPTURE lasts exactly one cycle:
  - clk_capture=1
  - clear the timeout counter
  - go to WAIT
- WAIT, when val_out is sampled 1:
  - clip hw to min(hw, N)
  - sum += clipped value; update hw_min/hw_max; count++
  - if count was 2^LOG2_SAMPLES−1, pulse done and go to IDLE; otherwise go to LAUNCH
- WAIT, when the timeout counter reaches TIMEOUT:
  - set err=1, pulse done, go to IDLE
  - sum/min/max keep their partial values
- val_out sampled in IDLE, LAUNCH or CAPTURE is ignored; there is no buffering.
- start while busy is ignored.
- en=0 in any state: go to IDLE synchronously, drive pulse outputs 0, no done pulse, result registers hold.
- Output definitions:
  - busy = (state != IDLE)
  - avg is combinational from sum
  - all other outputs are registered
- Arithmetic:
  - sum cannot overflow; maximum is N·2^LOG2_SAMPLES = 1024 at defaults, which fits 11 bits
  - avg ≤ N fits HW_W

## Timing
- Reset (async) sets every output and all state to 0 and the FSM to IDLE; hw_min resets to 0, not N.
- Let edge E0 be the edge that samples start.
- Per sample:
  - clk_launch/val_in high during [E0,E1)
  - clk_capture high during [E1,E2)
  - first val_out sampling edge is E3
- Minimum per-sample period is 3 cycles, with the next launch back-to-back.
- A full batch takes at minimum 3·2^LOG2_SAMPLES cycles: done is high during [E48,E49) at defaults, and busy falls at the same edge.
- Timeout: with no val_out, err and done rise at edge E2+TIMEOUT (E18 at defaults).
- done and err become visible together; err holds until the next accepted start or reset.
- Reset asserted mid-batch: pulses stop immediately and the block re-armed after release.

## Structure
- Shared package `tdc_pkg` holds:
  - state enum `tdc_seq_state_t` {IDLE, LAUNCH, CAPTURE, WAIT}
  - HW_W derivation as function `hw_width(N)`
- Sub-module `tdc_stats`: clip, accumulate and min/max registers, with clear/accumulate strobes from the FSM.
- Counters and FSM stay in `tdc_seq`.

## Test plan
- Constant hw=20, val_out one cycle after each capture → done at E48, sum=320, avg=20, hw_min=hw_max=20, err=0.
- hw ramps 0..15 across samples → sum=120, avg=7, hw_min=0, hw_max=15.
- val_out never asserted → done and err at E18, busy low at E18, exactly one launch and one capture pulse.
- hw=100 on every sample → clipped: sum=1024, avg=64, hw_max=64.
- Two kinds of ignored input:
  - stale val_out held high during LAUNCH/CAPTURE → ignored; sample taken only in WAIT
  - start pulsed mid-batch → no restart, done still at E48
- en dropped at sample 5 → busy=0 next cycle, no done pulse; rst asserted mid-batch → all outputs 0 asynchronously; a new start then completes a normal batch.
